// File: rtl/dcm_lock_supervisor_pkg.sv
// -----------------------------------------------------------------------------
// dcm_lock_supervisor_pkg
//   Shared definitions for the DCM lock supervisor:
//     - state_e    : 2-bit FSM state encoding (ST_PULSE_RST, ST_WAIT_LOCK,
//                    ST_QUALIFY, ST_LOCKED)
//     - STATUS_*   : bit positions of the DCM STATUS "clock stopped" flags
//     - max3()     : helper used to size the shared cycle counter
// -----------------------------------------------------------------------------
package dcm_lock_supervisor_pkg;

  typedef enum logic [1:0] {
    ST_PULSE_RST = 2'd0,
    ST_WAIT_LOCK = 2'd1,
    ST_QUALIFY   = 2'd2,
    ST_LOCKED    = 2'd3
  } state_e;

  // DCM STATUS[1] = CLKIN stopped, STATUS[2] = CLKFX stopped
  localparam int STATUS_CLKIN_STOP_BIT = 1;
  localparam int STATUS_CLKFX_STOP_BIT = 2;

  // Largest of three integers
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) begin
      m = b;
    end else begin
      m = m;
    end
    if (c > m) begin
      m = c;
    end else begin
      m = m;
    end
    return m;
  endfunction

endpackage

// File: rtl/dcm_lock_supervisor_sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff
//   Two-flop synchroniser for signals asynchronous to clk_i.
//   Ports:
//     clk_i   in   1      destination clock
//     rst_ni  in   1      asynchronous active-low reset (flops clear to 0)
//     d_i     in   WIDTH  asynchronous input
//     q_o     out  WIDTH  synchronised output (2 cycles of latency)
// -----------------------------------------------------------------------------
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  // Metastability stage followed by the stable output stage
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/dcm_lock_supervisor.sv
// -----------------------------------------------------------------------------
// dcm_lock_supervisor
//   Drives the DCM RST pin and qualifies its LOCKED output in the clk_i domain.
//   Sequence: pulse DCM reset, wait for LOCKED, require it to stay stable for
//   STABLE_CYCLES, then report a qualified lock. Lock loss or lock timeout
//   re-runs the sequence and is counted in relock_cnt_o (saturating).
//
//   Optional feature macro: DCM_STATUS_EN
//     When defined, DCM STATUS[2] (CLKFX stopped) and STATUS[1] (CLKIN stopped)
//     are synchronised and treated as a lock loss. When undefined,
//     dcm_status_i is ignored.
//
//   Ports:
//     clk_i          in   1      12 MHz system clock
//     resetn_i       in   1      asynchronous active-low reset
//     dcm_locked_i   in   1      raw DCM LOCKED (asynchronous)
//     dcm_status_i   in   8      raw DCM STATUS bus (DCM_STATUS_EN only)
//     dcm_rst_o      out  1      DCM RST, active high, registered
//     lock_stable_o  out  1      qualified lock, registered
//     timeout_o      out  1      sticky WAIT_LOCK timeout flag
//     relock_cnt_o   out  CNT_W  saturating re-lock attempt count
// -----------------------------------------------------------------------------
module dcm_lock_supervisor
  import dcm_lock_supervisor_pkg::*;
#(
  parameter int RST_CYCLES    = 4,
  parameter int LOCK_TIMEOUT  = 120000,
  parameter int STABLE_CYCLES = 1200,
  parameter int CNT_W         = 8
) (
  input  logic             clk_i,
  input  logic             resetn_i,
  input  logic             dcm_locked_i,
  input  logic [7:0]       dcm_status_i,
  output logic             dcm_rst_o,
  output logic             lock_stable_o,
  output logic             timeout_o,
  output logic [CNT_W-1:0] relock_cnt_o
);

  localparam int CNT_MAX = max3(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  // Terminal values of the shared counter in each timed state
  localparam logic [CW-1:0] RST_LAST    = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST     = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] STABLE_LAST = CW'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RELOCK_MAX = {CNT_W{1'b1}};

  logic lk_s;
  logic status_bad_s;
  logic status_unused_s;
  logic relock_inc_s;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             dcm_rst_q, dcm_rst_d;
  logic             lock_stable_q, lock_stable_d;
  logic             timeout_q, timeout_d;
  logic [CNT_W-1:0] relock_cnt_q, relock_cnt_d;

  sync_2ff #(.WIDTH(1)) u_lock_sync (
    .clk_i  (clk_i),
    .rst_ni (resetn_i),
    .d_i    (dcm_locked_i),
    .q_o    (lk_s)
  );

`ifdef DCM_STATUS_EN
  logic [1:0] status_sync_s;

  sync_2ff #(.WIDTH(2)) u_status_sync (
    .clk_i  (clk_i),
    .rst_ni (resetn_i),
    .d_i    ({dcm_status_i[STATUS_CLKFX_STOP_BIT], dcm_status_i[STATUS_CLKIN_STOP_BIT]}),
    .q_o    (status_sync_s)
  );

  assign status_bad_s = |status_sync_s;
`else
  assign status_bad_s = 1'b0;
`endif

  // Remaining STATUS bits carry no information for this block
  assign status_unused_s = ^dcm_status_i;

  // Next-state logic; cnt counts elapsed cycles and is cleared on every
  // state change so each timed state starts from zero.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q + CW'(1);
    timeout_d    = timeout_q;
    relock_inc_s = 1'b0;
    case (state_q)
      ST_PULSE_RST: begin
        if (cnt_q == RST_LAST) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
        end else begin
          state_d = ST_PULSE_RST;
        end
      end
      ST_WAIT_LOCK: begin
        if (status_bad_s) begin
          // Stopped clock: restart without flagging a timeout
          state_d      = ST_PULSE_RST;
          cnt_d        = '0;
          relock_inc_s = 1'b1;
        end else if (lk_s) begin
          state_d = ST_QUALIFY;
          cnt_d   = '0;
        end else if (cnt_q == TO_LAST) begin
          state_d      = ST_PULSE_RST;
          cnt_d        = '0;
          timeout_d    = 1'b1;
          relock_inc_s = 1'b1;
        end else begin
          state_d = ST_WAIT_LOCK;
        end
      end
      ST_QUALIFY: begin
        if (!lk_s || status_bad_s) begin
          // LOCKED chatters during acquisition: retry the wait, no DCM reset
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == STABLE_LAST) begin
          state_d = ST_LOCKED;
          cnt_d   = '0;
        end else begin
          state_d = ST_QUALIFY;
        end
      end
      ST_LOCKED: begin
        cnt_d = '0;
        if (!lk_s || status_bad_s) begin
          state_d      = ST_PULSE_RST;
          relock_inc_s = 1'b1;
        end else begin
          state_d = ST_LOCKED;
        end
      end
      default: begin
        state_d = ST_PULSE_RST;
        cnt_d   = '0;
      end
    endcase

    if (relock_inc_s && (relock_cnt_q != RELOCK_MAX)) begin
      relock_cnt_d = relock_cnt_q + CNT_W'(1);
    end else begin
      relock_cnt_d = relock_cnt_q;
    end

    // Outputs registered from the next state so they change on state entry
    dcm_rst_d     = (state_d == ST_PULSE_RST);
    lock_stable_d = (state_d == ST_LOCKED);
  end

  // State, counter and registered outputs
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state_q       <= ST_PULSE_RST;
      cnt_q         <= '0;
      dcm_rst_q     <= 1'b1;
      lock_stable_q <= 1'b0;
      timeout_q     <= 1'b0;
      relock_cnt_q  <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      dcm_rst_q     <= dcm_rst_d;
      lock_stable_q <= lock_stable_d;
      timeout_q     <= timeout_d;
      relock_cnt_q  <= relock_cnt_d;
    end
  end

  assign dcm_rst_o     = dcm_rst_q;
  assign lock_stable_o = lock_stable_q;
  assign timeout_o     = timeout_q;
  assign relock_cnt_o  = relock_cnt_q;

endmodule

// File: tb/tb_dcm_lock_supervisor.sv
// -----------------------------------------------------------------------------
// tb_dcm_lock_supervisor
//   Directed bench for dcm_lock_supervisor with RST_CYCLES=4, LOCK_TIMEOUT=50,
//   STABLE_CYCLES=10, CNT_W=4. Inputs change 1 time unit after a rising edge
//   and outputs are sampled 1 time unit after a rising edge.
// -----------------------------------------------------------------------------
module tb_dcm_lock_supervisor;

  logic       clk_i = 1'b0;
  logic       resetn_i;
  logic       dcm_locked_i;
  logic [7:0] dcm_status_i;
  logic       dcm_rst_o;
  logic       lock_stable_o;
  logic       timeout_o;
  logic [3:0] relock_cnt_o;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic       resetn;
    logic       locked;
    int         adv;
    logic       e_rst;
    logic       e_stable;
    logic       e_to;
    logic [3:0] e_cnt;
    string      name;
  } vec_t;

  vec_t vt [0:11];

  dcm_lock_supervisor #(
    .RST_CYCLES    (4),
    .LOCK_TIMEOUT  (50),
    .STABLE_CYCLES (10),
    .CNT_W         (4)
  ) dut (
    .clk_i         (clk_i),
    .resetn_i      (resetn_i),
    .dcm_locked_i  (dcm_locked_i),
    .dcm_status_i  (dcm_status_i),
    .dcm_rst_o     (dcm_rst_o),
    .lock_stable_o (lock_stable_o),
    .timeout_o     (timeout_o),
    .relock_cnt_o  (relock_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic step(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string nm, input logic e_rst, input logic e_stable,
                         input logic e_to, input logic [3:0] e_cnt);
    chk({nm, "_dcm_rst"},  32'(dcm_rst_o),     32'(e_rst));
    chk({nm, "_stable"},   32'(lock_stable_o), 32'(e_stable));
    chk({nm, "_timeout"},  32'(timeout_o),     32'(e_to));
    chk({nm, "_relock"},   32'(relock_cnt_o),  32'(e_cnt));
  endtask

  initial begin
    int exp_cnt;

    // Cycle numbers: edges counted from the last input change
    vt[0]  = '{1'b0, 1'b0, 2,  1'b1, 1'b0, 1'b0, 4'd0, "reset"};
    vt[1]  = '{1'b1, 1'b0, 3,  1'b1, 1'b0, 1'b0, 4'd0, "s1_pulse_hi"};
    vt[2]  = '{1'b1, 1'b0, 1,  1'b0, 1'b0, 1'b0, 4'd0, "s1_pulse_end"};
    vt[3]  = '{1'b1, 1'b0, 49, 1'b0, 1'b0, 1'b0, 4'd0, "s1_pre_timeout"};
    vt[4]  = '{1'b1, 1'b0, 1,  1'b1, 1'b0, 1'b1, 4'd1, "s1_timeout"};
    vt[5]  = '{1'b1, 1'b0, 3,  1'b1, 1'b0, 1'b1, 4'd1, "s1_repulse"};
    vt[6]  = '{1'b1, 1'b0, 1,  1'b0, 1'b0, 1'b1, 4'd1, "s1_repulse_end"};
    vt[7]  = '{1'b0, 1'b0, 2,  1'b1, 1'b0, 1'b0, 4'd0, "s2_reset"};
    vt[8]  = '{1'b1, 1'b0, 4,  1'b0, 1'b0, 1'b0, 4'd0, "s2_wait"};
    vt[9]  = '{1'b1, 1'b0, 20, 1'b0, 1'b0, 1'b0, 4'd0, "s2_pre_lock"};
    vt[10] = '{1'b1, 1'b1, 12, 1'b0, 1'b0, 1'b0, 4'd0, "s2_qualify"};
    vt[11] = '{1'b1, 1'b1, 1,  1'b0, 1'b1, 1'b0, 4'd0, "s2_locked"};

    resetn_i     = 1'b0;
    dcm_locked_i = 1'b0;
    dcm_status_i = 8'h00;
    step(1);

    for (int i = 0; i < 12; i++) begin
      resetn_i     = vt[i].resetn;
      dcm_locked_i = vt[i].locked;
      step(vt[i].adv);
      chk_all(vt[i].name, vt[i].e_rst, vt[i].e_stable, vt[i].e_to, vt[i].e_cnt);
    end

    // Repeated lock loss from LOCKED; count saturates at 15
    exp_cnt = 0;
    for (int k = 0; k < 20; k++) begin
      exp_cnt = (exp_cnt < 15) ? exp_cnt + 1 : 15;
      dcm_locked_i = 1'b0;
      step(2);
      chk("s4_before_loss", 32'(lock_stable_o), 32'd1);
      step(1);
      chk("s4_loss_stable", 32'(lock_stable_o), 32'd0);
      chk("s4_loss_relock", 32'(relock_cnt_o), 32'(exp_cnt));
      chk("s4_loss_dcm_rst", 32'(dcm_rst_o), 32'd1);
      step(3);
      chk("s4_pulse_hi", 32'(dcm_rst_o), 32'd1);
      step(1);
      chk("s4_pulse_end", 32'(dcm_rst_o), 32'd0);
      dcm_locked_i = 1'b1;
      step(12);
      chk("s4_relock_pre", 32'(lock_stable_o), 32'd0);
      step(1);
      chk("s4_relock", 32'(lock_stable_o), 32'd1);
    end
    chk("s4_timeout_clear", 32'(timeout_o), 32'd0);

    // Reset asserted mid-cycle while in QUALIFY
    dcm_locked_i = 1'b0;
    step(7);
    chk("s5_in_wait", 32'(dcm_rst_o), 32'd0);
    dcm_locked_i = 1'b1;
    step(5);
    #2;
    resetn_i = 1'b0;
    #1;
    chk_all("s5_async_reset", 1'b1, 1'b0, 1'b0, 4'd0);
    step(1);
    resetn_i = 1'b1;
    step(3);
    chk("s5_pulse_hi", 32'(dcm_rst_o), 32'd1);
    step(1);
    chk("s5_pulse_end", 32'(dcm_rst_o), 32'd0);
    step(10);
    chk("s5_pre_lock", 32'(lock_stable_o), 32'd0);
    step(1);
    chk("s5_locked", 32'(lock_stable_o), 32'd1);

    // Chatter in QUALIFY: back to WAIT_LOCK, no DCM reset
    resetn_i     = 1'b0;
    dcm_locked_i = 1'b0;
    step(1);
    resetn_i = 1'b1;
    step(4);
    chk("s3_wait", 32'(dcm_rst_o), 32'd0);
    dcm_locked_i = 1'b1;
    step(5);
    dcm_locked_i = 1'b0;
    step(1);
    dcm_locked_i = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      step(1);
      chk("s3_no_pulse", 32'(dcm_rst_o), 32'd0);
      chk("s3_not_yet", 32'(lock_stable_o), 32'd0);
    end
    step(1);
    chk("s3_locked", 32'(lock_stable_o), 32'd1);
    chk("s3_relock", 32'(relock_cnt_o), 32'd0);

    // One-cycle CLKIN-stopped pulse while LOCKED
    dcm_status_i = 8'h02;
    step(1);
    dcm_status_i = 8'h00;
    step(2);
`ifdef DCM_STATUS_EN
    chk_all("s6_status_loss", 1'b1, 1'b0, 1'b0, 4'd1);
    step(3);
    chk("s6_pulse_hi", 32'(dcm_rst_o), 32'd1);
    step(1);
    chk("s6_pulse_end", 32'(dcm_rst_o), 32'd0);
`else
    chk_all("s6_status_ignored", 1'b0, 1'b1, 1'b0, 4'd0);
    step(4);
    chk("s6_still_locked", 32'(lock_stable_o), 32'd1);
    chk("s6_no_pulse", 32'(dcm_rst_o), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
